// File: rtl/alu_issue_ctrl.sv
// Issue controller sitting between a requester and a combinational/multicycle ALU:
// accepts one operation at a time, drives the ALU, and holds the result until consumed.
module alu_issue_ctrl #(
  parameter int MULDIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_z,
  output logic        rsp_illegal,
  output logic [15:0] op_count,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // req_ready is 1 only in IDLE; rsp_valid is 1 only in RESP, and the response
  // payload stays frozen until the rsp_ready handshake.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_MUL      = 4'b1011;
  localparam logic [3:0] OP_DIV      = 4'b1100;
  localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [3:0]  alu_op_q;
  logic [31:0] rsp_z_q;
  logic        rsp_illegal_q;
  logic [15:0] count_q;

  logic accept;
  logic op_legal;
  logic op_muldiv;
  logic exec_done;
  logic rsp_done;

  assign op_legal  = (req_op <= OP_DIV);
  assign op_muldiv = (req_op == OP_MUL) || (req_op == OP_DIV);
  assign accept    = (state_q == IDLE) && req_valid;
  assign exec_done = (state_q == EXEC) && (cnt_q == 4'd0);
  assign rsp_done  = (state_q == RESP) && rsp_ready;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = op_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The ALU-facing registers double as the operand capture: an illegal opcode
  // never reaches the ALU, so they only load on legal acceptance.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      alu_a_q  <= 32'd0;
      alu_b_q  <= 32'd0;
      alu_op_q <= 4'd0;
      cnt_q    <= 4'd0;
    end else if (accept && op_legal) begin
      alu_a_q  <= req_a;
      alu_b_q  <= req_b;
      alu_op_q <= req_op;
      cnt_q    <= op_muldiv ? MULDIV_LOAD : 4'd0;
    end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rsp_z_q       <= 32'd0;
      rsp_illegal_q <= 1'b0;
    end else if (accept && !op_legal) begin
      rsp_z_q       <= 32'd0;
      rsp_illegal_q <= 1'b1;
    end else if (exec_done) begin
      rsp_z_q       <= alu_result;
      rsp_illegal_q <= 1'b0;
    end
  end

  // Counts consumed responses only, so an aborted operation never shows up here.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q <= 16'd0;
    end else if (rsp_done) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign rsp_z       = rsp_z_q;
  assign rsp_illegal = rsp_illegal_q;
  assign op_count    = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a reference ALU answers the DUT's ALU port and
// a scoreboard queue holds {illegal, result} expected for each issued request.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_z;
  logic        rsp_illegal;
  logic [15:0] op_count;
  logic [1:0]  state_dbg;

  logic [32:0] exp_q[$];
  logic [15:0] exp_cnt;
  int          checks;
  int          errors;

  alu_issue_ctrl #(.MULDIV_CYCLES(8)) dut (
    .clock       (clock),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_z       (rsp_z),
    .rsp_illegal (rsp_illegal),
    .op_count    (op_count),
    .state_dbg   (state_dbg)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] aa;
    logic [63:0] rot;
    aa = {a, a};
    case (op)
      4'd0:  alu_fn = a & b;
      4'd1:  alu_fn = a | b;
      4'd2:  alu_fn = -a;
      4'd3:  alu_fn = ~a;
      4'd4:  alu_fn = a >> b[4:0];
      4'd5:  alu_fn = $unsigned($signed(a) >>> b[4:0]);
      4'd6:  alu_fn = a << b[4:0];
      4'd7: begin
        rot = aa >> b[4:0];
        alu_fn = rot[31:0];
      end
      4'd8: begin
        rot = aa << b[4:0];
        alu_fn = rot[63:32];
      end
      4'd9:  alu_fn = a + b;
      4'd10: alu_fn = a - b;
      4'd11: alu_fn = a * b;
      4'd12: alu_fn = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: alu_fn = 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // drive one request; returns #1 after the acceptance edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    exp_q.push_back({(op > 4'd12), (op > 4'd12) ? 32'd0 : alu_fn(op, a, b)});
    tick();
    req_valid = 1'b0;
    req_op    = 4'($urandom_range(0, 15));
    req_a     = $urandom();
    req_b     = $urandom();
  endtask

  // counts edges after acceptance until rsp_valid, then scores the payload
  task automatic wait_rsp(input int exp_lat);
    int n;
    logic [32:0] e;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("rsp_latency", n, exp_lat);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed response expected none queued");
    end else begin
      e = exp_q.pop_front();
      chk("rsp_z", rsp_z, e[31:0]);
      chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e[32]});
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
    chk("op_count", {16'd0, op_count}, {16'd0, exp_cnt});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_z"}, rsp_z, 32'd0);
    chk({tag, "_rsp_illegal"}, {31'd0, rsp_illegal}, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_op"}, {28'd0, alu_op}, 32'd0);
    chk({tag, "_op_count"}, {16'd0, op_count}, 32'd0);
    chk({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] held_z;
    checks    = 0;
    errors    = 0;
    exp_cnt   = 16'd0;
    clear     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    rsp_ready = 1'b1;

    #12;
    chk_reset_vals("reset");
    req_valid = 1'b1;
    tick();
    chk_reset_vals("reset_clocked");
    req_valid = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    tick();

    // and
    issue(4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    chk("and_alu_op", {28'd0, alu_op}, 32'd0);
    chk("and_state_exec", {30'd0, state_dbg}, 32'd1);
    chk("and_rsp_valid_exec", {31'd0, rsp_valid}, 32'd0);
    chk("and_req_ready_exec", {31'd0, req_ready}, 32'd0);
    wait_rsp(1);
    chk("and_literal", rsp_z, 32'h00F0_000F);
    finish_rsp();
    chk("and_alu_op_held", {28'd0, alu_op}, 32'd0);

    // mul: eight edges of EXEC
    a = $urandom();
    b = $urandom();
    issue(4'b1011, a, b);
    chk("mul_alu_op", {28'd0, alu_op}, 32'd11);
    chk("mul_alu_a", alu_a, a);
    chk("mul_alu_b", alu_b, b);
    wait_rsp(8);
    finish_rsp();

    // illegal: straight to RESP, ALU port untouched
    issue(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("ill_alu_op_kept", {28'd0, alu_op}, 32'd11);
    chk("ill_alu_a_kept", alu_a, a);
    wait_rsp(0);
    finish_rsp();

    // sweep the single-cycle opcodes, plus div and the other illegal codes
    for (int op = 0; op <= 15; op++) begin
      a = $urandom();
      b = (op == 12) ? 32'($urandom_range(1, 1000)) : $urandom();
      issue(4'(op), a, b);
      wait_rsp((op > 12) ? 0 : ((op >= 11) ? 8 : 1));
      finish_rsp();
    end

    // backpressure with a competing request held on the input
    rsp_ready = 1'b0;
    issue(4'd9, 32'h0000_0010, 32'h0000_0020);
    wait_rsp(1);
    held_z = rsp_z;
    req_valid = 1'b1;
    req_op    = 4'd10;
    req_b     = 32'h0000_0005;
    for (int i = 0; i < 5; i++) begin
      req_a = $urandom();
      tick();
      chk("bp_rsp_z_stable", rsp_z, held_z);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    req_a = 32'h0000_0100;
    rsp_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("bp_state_idle", {30'd0, state_dbg}, 32'd0);
    chk("bp_op_count", {16'd0, op_count}, {16'd0, exp_cnt});
    exp_q.push_back({1'b0, 32'h0000_00FB});
    tick();
    req_valid = 1'b0;
    chk("bp_second_accept", {30'd0, state_dbg}, 32'd1);
    chk("bp_second_alu_a", alu_a, 32'h0000_0100);
    wait_rsp(1);
    finish_rsp();

    // clear in the middle of a div
    issue(4'b1100, 32'd1000, 32'd7);
    tick();
    tick();
    #2;
    clear = 1'b0;
    #1;
    chk_reset_vals("abort");
    exp_q.delete();
    exp_cnt = 16'd0;
    @(negedge clock);
    clear = 1'b1;
    tick();
    issue(4'b0001, 32'd1, 32'd2);
    wait_rsp(1);
    chk("or_after_abort", rsp_z, 32'd3);
    finish_rsp();

    // counter wrap
    @(negedge clock);
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    exp_cnt = 16'hFFFE;
    chk("preload_count", {16'd0, op_count}, 32'h0000_FFFE);
    tick();
    issue(4'd13, 32'd0, 32'd0);
    wait_rsp(0);
    finish_rsp();
    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_FFFF);
    wait_rsp(1);
    finish_rsp();
    chk("wrap_literal", {16'd0, op_count}, 32'd0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
